// File: rtl/gearbox_align_pkg.sv
// Shared types, constants and helpers for the gearbox word-alignment controller.
package gearbox_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_SLIP   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } align_state_e;

  localparam int unsigned GB_WORD_W = 14;

  // 7:1 clock pattern 1100011, doubled across the two words of one SCLK.
  localparam logic [GB_WORD_W-1:0] TRAIN_PATTERN_DEF = 14'h31E3;

  // Bits needed to hold every value 0..max_val (never less than 1).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((max_val >> w) != 0) w++;
    return w;
  endfunction

endpackage

// File: rtl/gearbox_align_ctrl_timer.sv
// Loadable down-counter with a registered zero flag; times SETTLE and SLIP.
module align_cyc_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         zero_q;

  // Load wins; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register and zero flag, kept coherent by deriving both from cnt_d.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/gearbox_align_ctrl.sv
// Word-alignment controller for the 1:14 DDR input gearbox: slips until the
// training word is seen stably, holds lock, and reports loss of lock.
module gearbox_align_ctrl
  import gearbox_align_pkg::*;
#(
  parameter int unsigned       DATA_W        = 14,
  parameter logic [DATA_W-1:0] TRAIN_PATTERN = DATA_W'(TRAIN_PATTERN_DEF),
  parameter int unsigned       MATCH_CNT     = 4,
  parameter int unsigned       SETTLE_CYC    = 8,
  parameter int unsigned       SLIP_PULSE_W  = 2,
  parameter int unsigned       MAX_SLIPS     = 14,
  parameter int unsigned       MISS_LIMIT    = 3
) (
  input  logic                        SCLK,
  input  logic                        RSTB,
  input  logic                        start,
  input  logic                        auto_relock,
  input  logic [DATA_W-1:0]           data_in,
  output logic                        alignwd,
  output logic                        busy,
  output logic                        locked,
  output logic                        fail,
  output logic                        lol,
  output logic [cnt_w(MAX_SLIPS)-1:0] slip_count
);

  localparam int unsigned SLIP_CW  = cnt_w(MAX_SLIPS);
  localparam int unsigned MATCH_W  = cnt_w(MATCH_CNT);
  localparam int unsigned MISS_W   = cnt_w(MISS_LIMIT);
  localparam int unsigned TMR_MAX  = (SETTLE_CYC > SLIP_PULSE_W) ? SETTLE_CYC : SLIP_PULSE_W;
  localparam int unsigned TMR_W    = cnt_w(TMR_MAX);

  localparam logic [TMR_W-1:0]   SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0]   SLIP_LD   = TMR_W'(SLIP_PULSE_W - 1);
  localparam logic [SLIP_CW-1:0] SLIP_MAX  = SLIP_CW'(MAX_SLIPS);
  localparam logic [MATCH_W-1:0] MATCH_LST = MATCH_W'(MATCH_CNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LST  = MISS_W'(MISS_LIMIT - 1);

  align_state_e       state_q, state_d;
  logic [SLIP_CW-1:0] slip_q, slip_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               lol_d;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_zero;
  logic               pat_hit;

  logic alignwd_q, busy_q, locked_q, fail_q, lol_q;

  assign pat_hit = (data_in == TRAIN_PATTERN);

  align_cyc_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk_i      (SCLK),
    .rst_i      (RSTB),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Next-state, counter and timer-load decisions.
  always_comb begin
    state_d  = state_q;
    slip_d   = slip_q;
    match_d  = match_q;
    miss_d   = miss_q;
    lol_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;

    case (state_q)
      ST_IDLE, ST_FAIL: begin
        if (start) begin
          state_d  = ST_SETTLE;
          slip_d   = '0;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end
      end

      ST_SETTLE: begin
        if (tmr_zero) begin
          state_d = ST_CHECK;
          match_d = '0;
        end
      end

      ST_CHECK: begin
        if (pat_hit) begin
          if (match_q == MATCH_LST) begin
            state_d = ST_LOCKED;
            match_d = '0;
            miss_d  = '0;
          end else begin
            match_d = match_q + MATCH_W'(1);
          end
        end else begin
          match_d = '0;
          if (slip_q < SLIP_MAX) begin
            state_d  = ST_SLIP;
            slip_d   = slip_q + SLIP_CW'(1);
            tmr_load = 1'b1;
            tmr_val  = SLIP_LD;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end

      ST_SLIP: begin
        if (tmr_zero) begin
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end
      end

      ST_LOCKED: begin
        if (pat_hit) begin
          miss_d = '0;
        end else if (miss_q == MISS_LST) begin
          miss_d = '0;
          lol_d  = 1'b1;
          if (auto_relock) begin
            state_d  = ST_SETTLE;
            slip_d   = '0;
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          miss_d = miss_q + MISS_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge SCLK) begin
    if (RSTB) begin
      state_q <= ST_IDLE;
      slip_q  <= '0;
      match_q <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      slip_q  <= slip_d;
      match_q <= match_d;
      miss_q  <= miss_d;
    end
  end

  // Status outputs registered from the next state so they line up with it.
  always_ff @(posedge SCLK) begin
    if (RSTB) begin
      alignwd_q <= 1'b0;
      busy_q    <= 1'b0;
      locked_q  <= 1'b0;
      fail_q    <= 1'b0;
      lol_q     <= 1'b0;
    end else begin
      alignwd_q <= (state_d == ST_SLIP);
      busy_q    <= (state_d == ST_SETTLE) || (state_d == ST_CHECK) || (state_d == ST_SLIP);
      locked_q  <= (state_d == ST_LOCKED);
      fail_q    <= (state_d == ST_FAIL);
      lol_q     <= lol_d;
    end
  end

  assign alignwd    = alignwd_q;
  assign busy       = busy_q;
  assign locked     = locked_q;
  assign fail       = fail_q;
  assign lol        = lol_q;
  assign slip_count = slip_q;

endmodule

// File: tb/tb_gearbox_align_ctrl.sv
// Bench for gearbox_align_ctrl: cycle-timeline reference model plus directed
// and randomized scenarios driven through a simple rotating-gearbox source.
module tb_gearbox_align_ctrl;

  localparam logic [13:0] PAT        = 14'h31E3;
  localparam int          MATCH_CNT  = 4;
  localparam int          SETTLE_CYC = 8;
  localparam int          SLIP_W     = 2;
  localparam int          MAX_SLIPS  = 14;
  localparam int          MISS_LIMIT = 3;

  logic        SCLK = 1'b0;
  logic        RSTB = 1'b1;
  logic        start = 1'b0;
  logic        auto_relock = 1'b0;
  logic [13:0] data_in;
  logic        alignwd, busy, locked, fail, lol;
  logic [3:0]  slip_count;

  int checks = 0;
  int errors = 0;

  // Stimulus source: forced word, or training pattern rotated by the residual misalignment.
  logic        use_force = 1'b1;
  logic [13:0] force_word = PAT;
  int          mis_base = 0;
  int          pulse_base = 0;
  int          pulse_cnt = 0;
  logic        prev_aw = 1'b0;

  function automatic logic [13:0] rotl14(input logic [13:0] x, input int k);
    logic [27:0] d;
    d = {x, x};
    return d[27-k -: 14];
  endfunction

  assign data_in = use_force ? force_word
                 : rotl14(PAT, (mis_base + 14 * 64 - (pulse_cnt - pulse_base)) % 14);

  always #5 SCLK = ~SCLK;

  // Gearbox model: every ALIGNWD pulse removes one bit of misalignment.
  always @(negedge SCLK) begin
    if (alignwd === 1'b1 && !prev_aw) pulse_cnt <= pulse_cnt + 1;
    prev_aw <= (alignwd === 1'b1);
  end

  gearbox_align_ctrl dut (
    .SCLK        (SCLK),
    .RSTB        (RSTB),
    .start       (start),
    .auto_relock (auto_relock),
    .data_in     (data_in),
    .alignwd     (alignwd),
    .busy        (busy),
    .locked      (locked),
    .fail        (fail),
    .lol         (lol),
    .slip_count  (slip_count)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  typedef enum int {M_IDLE, M_ALIGN, M_LOCKED, M_FAIL} mode_t;

  // Reference model in absolute cycle numbers: compare instants follow from
  // the latency rules, the slip pulse is a window after the mismatching compare.
  task automatic compare_loop();
    int    n = 0;
    mode_t mode = M_IDLE;
    int    next_cmp = 0;
    int    slip_start = -100;
    int    runs = 0;
    int    misses = 0;
    int    slips = 0;
    bit    lol_e;
    bit    hit;
    forever begin
      @(posedge SCLK);
      n++;
      hit   = (data_in == PAT);
      lol_e = 1'b0;
      if (RSTB) begin
        mode = M_IDLE; slips = 0; runs = 0; misses = 0; slip_start = -100;
      end else begin
        case (mode)
          M_IDLE, M_FAIL: if (start) begin
            mode = M_ALIGN; next_cmp = n + 1 + SETTLE_CYC; slips = 0; runs = 0;
          end
          M_ALIGN: if (n == next_cmp) begin
            if (hit) begin
              runs++;
              if (runs == MATCH_CNT) begin mode = M_LOCKED; misses = 0; end
              else next_cmp = n + 1;
            end else begin
              runs = 0;
              if (slips < MAX_SLIPS) begin
                slips++;
                slip_start = n;
                next_cmp = n + SLIP_W + SETTLE_CYC + 1;
              end else begin
                mode = M_FAIL;
              end
            end
          end
          M_LOCKED: begin
            if (hit) misses = 0;
            else begin
              misses++;
              if (misses == MISS_LIMIT) begin
                lol_e = 1'b1;
                if (auto_relock) begin
                  mode = M_ALIGN; next_cmp = n + 1 + SETTLE_CYC; slips = 0; runs = 0;
                end else begin
                  mode = M_IDLE;
                end
              end
            end
          end
          default: mode = M_IDLE;
        endcase
      end
      #1;
      chk("m_alignwd", {31'd0, alignwd},
          {31'd0, (mode == M_ALIGN) && (n >= slip_start) && (n < slip_start + SLIP_W)});
      chk("m_busy",   {31'd0, busy},   {31'd0, mode == M_ALIGN});
      chk("m_locked", {31'd0, locked}, {31'd0, mode == M_LOCKED});
      chk("m_fail",   {31'd0, fail},   {31'd0, mode == M_FAIL});
      chk("m_lol",    {31'd0, lol},    {31'd0, lol_e});
      chk("m_slip_count", {28'd0, slip_count}, 32'(slips));
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge SCLK);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_reset();
    RSTB = 1'b1;
    tick(2);
    RSTB = 1'b0;
  endtask

  function automatic logic cur(input int sel);
    case (sel)
      0:       return locked;
      1:       return fail;
      2:       return alignwd;
      default: return busy;
    endcase
  endfunction

  task automatic wait_for(input string what, input int sel, input int budget, output int took);
    took = -1;
    for (int i = 1; i <= budget; i++) begin
      if (cur(sel) === 1'b1) begin
        took = i;
        break;
      end
      tick(1);
    end
    if (took < 0) chk(what, 32'd0, 32'd1);
  endtask

  initial begin
    int t;
    int nlol;
    int pb;
    int burst;
    fork
      compare_loop();
    join_none

    // Reset values.
    tick(3);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_alignwd", {31'd0, alignwd}, 32'd0);
    chk("rst_slip_count", {28'd0, slip_count}, 32'd0);
    RSTB = 1'b0;
    tick(2);

    // Already aligned: lock 1+8+4 cycles after start, no slips.
    use_force = 1'b1; force_word = PAT;
    pulse_start();
    wait_for("aligned_lock_timeout", 0, 40, t);
    chk("aligned_lock_latency", 32'(t), 32'd13);
    chk("aligned_slip_count", {28'd0, slip_count}, 32'd0);
    pulse_start();
    tick(3);
    chk("start_in_locked_ignored", {31'd0, locked}, 32'd1);

    // Two misses then a hit keeps lock; three misses drop it.
    force_word = 14'h0000; tick(2); force_word = PAT; tick(4);
    chk("two_miss_keeps_lock", {31'd0, locked}, 32'd1);
    nlol = 0;
    force_word = 14'h0000;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (i == 2) force_word = PAT;
      if (lol === 1'b1) nlol++;
    end
    chk("lol_pulse_count", 32'(nlol), 32'd1);
    chk("lol_locked_low", {31'd0, locked}, 32'd0);
    chk("lol_idle_not_busy", {31'd0, busy}, 32'd0);

    // Automatic relock after loss of lock.
    auto_relock = 1'b1;
    pulse_start();
    wait_for("relock_first_lock", 0, 40, t);
    force_word = 14'h0000; tick(3); force_word = PAT;
    wait_for("relock_busy", 3, 5, t);
    wait_for("relock_lock", 0, 40, t);
    chk("relock_slip_count", {28'd0, slip_count}, 32'd0);
    auto_relock = 1'b0;

    // Misaligned by 3 bits: three slips then lock.
    do_reset();
    use_force = 1'b0; mis_base = 3; pb = pulse_cnt; pulse_base = pulse_cnt;
    pulse_start();
    wait_for("mis3_lock", 0, 200, t);
    chk("mis3_pulses", 32'(pulse_cnt - pb), 32'd3);
    chk("mis3_slip_count", {28'd0, slip_count}, 32'd3);

    // Never-matching data: 14 slips then sticky fail; restart clears it.
    do_reset();
    use_force = 1'b1; force_word = 14'h0000;
    pulse_start();
    tick(20);
    pulse_start();
    wait_for("nomatch_fail", 1, 400, t);
    chk("nomatch_fail", {31'd0, fail}, 32'd1);
    chk("nomatch_busy", {31'd0, busy}, 32'd0);
    chk("nomatch_slip_count", {28'd0, slip_count}, 32'd14);
    tick(5);
    chk("fail_sticky", {31'd0, fail}, 32'd1);
    pulse_start();
    chk("restart_fail_clr", {31'd0, fail}, 32'd0);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    chk("restart_slip_clr", {28'd0, slip_count}, 32'd0);
    force_word = PAT;
    wait_for("restart_lock", 0, 60, t);

    // Match counter reset: PAT, PAT, bad, PAT... gives exactly one slip.
    do_reset();
    pb = pulse_cnt;
    start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      if (i == 1) start = 1'b0;
      force_word = (i == 11) ? 14'h0000 : PAT;
    end
    chk("mreset_locked", {31'd0, locked}, 32'd1);
    chk("mreset_slip_count", {28'd0, slip_count}, 32'd1);
    chk("mreset_pulses", 32'(pulse_cnt - pb), 32'd1);

    // Reset in the middle of a slip pulse, with start held high.
    do_reset();
    force_word = 14'h0000;
    pulse_start();
    wait_for("slip_seen", 2, 40, t);
    RSTB = 1'b1; start = 1'b1;
    tick(1);
    chk("rst_mid_slip_alignwd", {31'd0, alignwd}, 32'd0);
    chk("rst_mid_slip_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_slip_count", {28'd0, slip_count}, 32'd0);
    start = 1'b0;
    tick(1);
    RSTB = 1'b0;
    tick(2);

    // Randomized traffic against the model.
    burst = 0;
    for (int c = 0; c < 3000; c++) begin
      tick(1);
      RSTB  = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 99) == 0) auto_relock = ~auto_relock;
      if ($urandom_range(0, 199) == 0) begin
        mis_base   = $urandom_range(0, 6);
        pulse_base = pulse_cnt;
        use_force  = 1'($urandom_range(0, 1));
      end
      if (burst > 0) begin
        force_word = 14'($urandom);
        burst--;
      end else begin
        force_word = PAT;
        if ($urandom_range(0, 39) == 0) burst = $urandom_range(1, 4);
      end
    end

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
